// File: rtl/pfd_lock_ctrl_pkg.sv
// Shared types and helpers for the PFD lock controller.
//  pfd_state_e : controller state encoding, also visible on the state debug port
//  ctrl_out_t  : registered control bundle driven towards the PFD/charge-pump macro
//  cnt_width   : width needed to hold 0..n-1 (never less than one bit)
package pfd_lock_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } pfd_state_e;

    typedef struct packed {
        logic pfd_resetb;
        logic cp_en;
        logic fast_mode;
        logic locked;
        logic fault;
    } ctrl_out_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/pfd_err_window.sv
// Per-reference-period phase error window.
//  clk, resetb      : clock, asynchronous active-low reset
//  win_en_i         : window active (loop running); low clears count and window-valid
//  clr_i            : clears err_last_o (loop disabled)
//  up_s_i, down_s_i : synchronised PFD flags; exactly one high counts as an error cycle
//  ref_tick_i       : closes the current window (its own sample included)
//  score_valid_o_c  : one-cycle pulse, a scored window closed this cycle
//  score_good_o_c   : that window's final count was within tolerance
//  err_last_o       : final count of the last scored window
module pfd_err_window #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_TOL = 2
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             win_en_i,
    input  logic             clr_i,
    input  logic             up_s_i,
    input  logic             down_s_i,
    input  logic             ref_tick_i,
    output logic             score_valid_o_c,
    output logic             score_good_o_c,
    output logic [CNT_W-1:0] err_last_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] err_last_q, err_last_d;
    logic [CNT_W-1:0] err_final;
    logic             win_valid_q, win_valid_d;
    logic             err_hit;

    // Both flags high is the PFD reset overlap, not phase error.
    assign err_hit = up_s_i ^ down_s_i;

    // Count, close and score the window; the first tick only opens it.
    always_comb begin
        err_final       = err_cnt_q;
        err_cnt_d       = err_cnt_q;
        err_last_d      = err_last_q;
        win_valid_d     = win_valid_q;
        score_valid_o_c = 1'b0;
        score_good_o_c  = 1'b0;

        if (err_hit && (err_cnt_q != CNT_MAX)) begin
            err_final = err_cnt_q + CNT_W'(1);
        end

        if (!win_en_i) begin
            err_cnt_d   = '0;
            win_valid_d = 1'b0;
        end else if (ref_tick_i) begin
            err_cnt_d   = '0;
            win_valid_d = 1'b1;
            if (win_valid_q) begin
                score_valid_o_c = 1'b1;
                score_good_o_c  = (err_final <= CNT_W'(LOCK_TOL));
                err_last_d      = err_final;
            end
        end else begin
            err_cnt_d = err_final;
        end

        if (clr_i) begin
            err_last_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            err_cnt_q   <= '0;
            err_last_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_last_q  <= err_last_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign err_last_o = err_last_q;

endmodule

// File: rtl/pfd_lock_ctrl.sv
// Sequencer and lock detector for the NOR-based PFD and its charge pump.
//  clk, resetb  : clock, asynchronous active-low reset
//  enable       : run the loop; low returns to IDLE next cycle
//  up_s, down_s : synchronised PFD up/down flags
//  ref_tick     : one-cycle pulse per reference edge
//  pfd_resetb   : low holds the PFD in reset
//  cp_en        : charge pump enable
//  fast_mode    : acquisition (high-bandwidth) current select
//  locked       : lock indicator
//  fault        : reference-loss indicator, sticky until enable drops
//  state        : current controller state (debug)
//  err_last     : error count of the last scored reference period
module pfd_lock_ctrl
    import pfd_lock_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned UNLOCK_CNT  = 4,
    parameter int unsigned SETTLE_CYC  = 32,
    parameter int unsigned REF_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               enable,
    input  logic               up_s,
    input  logic               down_s,
    input  logic               ref_tick,
    output logic               pfd_resetb,
    output logic               cp_en,
    output logic               fast_mode,
    output logic               locked,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   err_last
);

    localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYC);
    localparam int unsigned GOOD_W   = cnt_width(LOCK_CNT + 1);
    localparam int unsigned BAD_W    = cnt_width(UNLOCK_CNT + 1);
    localparam int unsigned WD_W     = cnt_width(REF_TIMEOUT);

    pfd_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    ctrl_out_t           out_q, out_d;
    logic                in_loop;
    logic                score_valid_c;
    logic                score_good_c;

    assign in_loop = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);

    pfd_err_window #(
        .CNT_W    (CNT_W),
        .LOCK_TOL (LOCK_TOL)
    ) u_err_window (
        .clk             (clk),
        .resetb          (resetb),
        .win_en_i        (in_loop),
        .clr_i           (!enable),
        .up_s_i          (up_s),
        .down_s_i        (down_s),
        .ref_tick_i      (ref_tick),
        .score_valid_o_c (score_valid_c),
        .score_good_o_c  (score_good_c),
        .err_last_o      (err_last)
    );

    // Next state, counters and the output set of the next state.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        good_d   = good_q;
        bad_d    = bad_q;
        wd_d     = wd_q;
        out_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_ACQUIRE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_ACQUIRE: begin
                if (score_valid_c) begin
                    if (score_good_c) begin
                        bad_d = '0;
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            good_d  = GOOD_W'(LOCK_CNT);
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else begin
                        good_d = '0;
                        if (bad_q != BAD_W'(UNLOCK_CNT)) begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (score_valid_c) begin
                    if (score_good_c) begin
                        bad_d = '0;
                        if (good_q != GOOD_W'(LOCK_CNT)) begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else begin
                        good_d = '0;
                        if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                            bad_d   = '0;
                            state_d = ST_ACQUIRE;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reference watchdog; a tick on the final cycle still rescues the loop.
        if (in_loop) begin
            if (ref_tick) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(REF_TIMEOUT - 1)) begin
                state_d = ST_FAULT;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end

        if (!enable) begin
            state_d = ST_IDLE;
        end

        // Counters restart on every fresh entry into their state.
        if (state_d != ST_SETTLE) begin
            settle_d = '0;
        end
        if ((state_d != ST_ACQUIRE) && (state_d != ST_LOCKED)) begin
            good_d = '0;
            bad_d  = '0;
            wd_d   = '0;
        end

        case (state_d)
            ST_ACQUIRE: begin
                out_d.pfd_resetb = 1'b1;
                out_d.cp_en      = 1'b1;
                out_d.fast_mode  = 1'b1;
            end
            ST_LOCKED: begin
                out_d.pfd_resetb = 1'b1;
                out_d.cp_en      = 1'b1;
                out_d.locked     = 1'b1;
            end
            ST_FAULT: begin
                out_d.fault = 1'b1;
            end
            default: begin
                out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            wd_q     <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            wd_q     <= wd_d;
            out_q    <= out_d;
        end
    end

    assign pfd_resetb = out_q.pfd_resetb;
    assign cp_en      = out_q.cp_en;
    assign fast_mode  = out_q.fast_mode;
    assign locked     = out_q.locked;
    assign fault      = out_q.fault;
    assign state      = state_q;

endmodule

// File: tb/tb_pfd_lock_ctrl.sv
// Bench for pfd_lock_ctrl: scenario table with hand-derived checkpoints,
// per-cycle comparison against a behavioural model, reset pulse, random traffic.
module tb_pfd_lock_ctrl;

    localparam int CNT_W       = 8;
    localparam int LOCK_TOL    = 2;
    localparam int LOCK_CNT    = 16;
    localparam int UNLOCK_CNT  = 4;
    localparam int SETTLE_CYC  = 32;
    localparam int REF_TIMEOUT = 1024;
    localparam int ERR_MAX     = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_ACQ    = 2;
    localparam int M_LOCK   = 3;
    localparam int M_FAULT  = 4;

    logic             clk = 1'b0;
    logic             resetb;
    logic             enable;
    logic             up_s;
    logic             down_s;
    logic             ref_tick;
    logic             pfd_resetb;
    logic             cp_en;
    logic             fast_mode;
    logic             locked;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] err_last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pfd_lock_ctrl #(
        .CNT_W       (CNT_W),
        .LOCK_TOL    (LOCK_TOL),
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_CNT  (UNLOCK_CNT),
        .SETTLE_CYC  (SETTLE_CYC),
        .REF_TIMEOUT (REF_TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .up_s       (up_s),
        .down_s     (down_s),
        .ref_tick   (ref_tick),
        .pfd_resetb (pfd_resetb),
        .cp_en      (cp_en),
        .fast_mode  (fast_mode),
        .locked     (locked),
        .fault      (fault),
        .state      (state),
        .err_last   (err_last)
    );

    // Behavioural model: mode, error accumulated this period, run lengths of
    // good/bad periods and quiet cycles since the last reference tick.
    int m_mode, m_settle, m_err, m_err_last, m_good, m_bad, m_quiet;
    bit m_open;

    task automatic model_reset();
        m_mode = M_IDLE; m_settle = 0; m_err = 0; m_err_last = 0;
        m_good = 0; m_bad = 0; m_quiet = 0; m_open = 0;
    endtask

    task automatic model_step(input bit en, input bit up, input bit dn, input bit tk);
        int nm;
        int e;
        nm = m_mode;
        case (m_mode)
            M_IDLE: if (en) begin nm = M_SETTLE; m_settle = 0; end
            M_SETTLE: begin
                m_settle++;
                if (m_settle >= SETTLE_CYC) begin
                    nm = M_ACQ; m_open = 0; m_err = 0; m_quiet = 0; m_good = 0; m_bad = 0;
                end
            end
            M_ACQ, M_LOCK: begin
                e = m_err + ((up != dn) ? 1 : 0);
                if (e > ERR_MAX) e = ERR_MAX;
                if (tk) begin
                    m_quiet = 0;
                    if (m_open) begin
                        m_err_last = e;
                        if (e <= LOCK_TOL) begin
                            if (m_good < LOCK_CNT) m_good++;
                            m_bad = 0;
                        end else begin
                            m_good = 0;
                            m_bad++;
                        end
                        if (m_mode == M_ACQ && m_good >= LOCK_CNT) nm = M_LOCK;
                        if (m_mode == M_LOCK && m_bad >= UNLOCK_CNT) begin
                            nm = M_ACQ; m_good = 0; m_bad = 0;
                        end
                    end
                    m_open = 1;
                    m_err  = 0;
                end else begin
                    m_err = e;
                    m_quiet++;
                    if (m_quiet >= REF_TIMEOUT) nm = M_FAULT;
                end
            end
            default: ;
        endcase
        if (!en) begin
            nm = M_IDLE;
            m_err_last = 0;
        end
        m_mode = nm;
    endtask

    task automatic check_vals(input string name, input int st, input int pr, input int cp,
                              input int fm, input int lk, input int ft, input int er);
        n_tests++;
        if (int'(state) != st || int'(pfd_resetb) != pr || int'(cp_en) != cp ||
            int'(fast_mode) != fm || int'(locked) != lk || int'(fault) != ft ||
            int'(err_last) != er) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d pfd_rb=%0b cp=%0b fast=%0b lock=%0b fault=%0b err=%0d, want st=%0d pfd_rb=%0d cp=%0d fast=%0d lock=%0d fault=%0d err=%0d",
                     name, $time, state, pfd_resetb, cp_en, fast_mode, locked, fault, err_last,
                     st, pr, cp, fm, lk, ft, er);
        end
    endtask

    task automatic check_model(input string name);
        check_vals(name, m_mode,
                   (m_mode == M_ACQ || m_mode == M_LOCK) ? 1 : 0,
                   (m_mode == M_ACQ || m_mode == M_LOCK) ? 1 : 0,
                   (m_mode == M_ACQ) ? 1 : 0,
                   (m_mode == M_LOCK) ? 1 : 0,
                   (m_mode == M_FAULT) ? 1 : 0,
                   m_err_last);
    endtask

    // Drive one cycle of inputs, advance the model, compare just after the edge.
    task automatic run_cycle(input bit en, input bit up, input bit dn, input bit tk);
        enable = en; up_s = up; down_s = dn; ref_tick = tk;
        @(posedge clk);
        model_step(en, up, dn, tk);
        #1;
        check_model("cycle");
    endtask

    // period 0: no ticks and no up pulses. up is high for the first up_hi cycles of each period.
    task automatic run_phase(input int en, input int up_hi, input int both,
                             input int period, input int cycles);
        int pos;
        bit up, tk;
        for (int k = 0; k < cycles; k++) begin
            pos = (period > 0) ? (k % period) : k;
            tk  = (period > 0) && (pos == period - 1);
            up  = (period > 0) && (pos < up_hi);
            run_cycle(en != 0, up, (both != 0) ? up : 1'b0, tk);
        end
    endtask

    typedef struct {
        int en; int up_hi; int both; int period; int cycles;
        int x_st; int x_pr; int x_cp; int x_fm; int x_lk; int x_ft; int x_er;
    } phase_t;

    phase_t tbl [22];

    task automatic run_random();
        int per, hi, np, pos;
        bit both, up, dn, tk;
        for (int s = 0; s < 30; s++) begin
            per  = int'($urandom_range(20, 150));
            hi   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 30)) : int'($urandom_range(0, 2));
            both = ($urandom_range(0, 3) == 0);
            np   = int'($urandom_range(4, 14));
            if ($urandom_range(0, 9) == 0) run_phase(0, 0, 0, 0, int'($urandom_range(1, 3)));
            if (s == 15) begin
                run_phase(1, 0, 0, 0, 1100);
                run_phase(0, 0, 0, 0, 1);
            end
            for (int k = 0; k < per * np; k++) begin
                pos = k % per;
                tk  = (pos == per - 1);
                up  = (pos < hi);
                dn  = both ? up : ($urandom_range(0, 63) == 0);
                run_cycle(1'b1, up, dn, tk);
            end
        end
    endtask

    initial begin
        //          en up  both per  cyc   st pr cp fm lk ft err
        tbl[0]  = '{0, 0,   0, 0,   5,    0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0,   0, 0,   32,   1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0,   0, 0,   1,    2, 1, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 1,   0, 100, 1600, 2, 1, 1, 1, 0, 0, 1};
        tbl[4]  = '{1, 1,   0, 100, 100,  3, 1, 1, 0, 1, 0, 1};
        tbl[5]  = '{1, 10,  0, 100, 300,  3, 1, 1, 0, 1, 0, 10};
        tbl[6]  = '{1, 1,   0, 100, 100,  3, 1, 1, 0, 1, 0, 1};
        tbl[7]  = '{1, 10,  0, 100, 300,  3, 1, 1, 0, 1, 0, 10};
        tbl[8]  = '{1, 10,  0, 100, 100,  2, 1, 1, 1, 0, 0, 10};
        tbl[9]  = '{1, 300, 0, 400, 400,  2, 1, 1, 1, 0, 0, 255};
        tbl[10] = '{1, 100, 1, 100, 100,  2, 1, 1, 1, 0, 0, 0};
        tbl[11] = '{0, 0,   0, 0,   1,    0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0,   0, 0,   33,   2, 1, 1, 1, 0, 0, 0};
        tbl[13] = '{1, 1,   0, 100, 1700, 3, 1, 1, 0, 1, 0, 1};
        tbl[14] = '{1, 0,   0, 0,   1023, 3, 1, 1, 0, 1, 0, 1};
        tbl[15] = '{1, 0,   0, 0,   1,    4, 0, 0, 0, 0, 1, 1};
        tbl[16] = '{1, 0,   0, 0,   50,   4, 0, 0, 0, 0, 1, 1};
        tbl[17] = '{0, 0,   0, 0,   1,    0, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{1, 0,   0, 0,   1,    1, 0, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 0,   0, 0,   32,   2, 1, 1, 1, 0, 0, 0};
        tbl[20] = '{1, 1,   0, 50,  100,  2, 1, 1, 1, 0, 0, 1};
        tbl[21] = '{0, 0,   0, 0,   1,    0, 0, 0, 0, 0, 0, 0};

        resetb = 1'b0; enable = 1'b0; up_s = 1'b0; down_s = 1'b0; ref_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_vals("reset", 0, 0, 0, 0, 0, 0, 0);
        resetb = 1'b1;

        for (int i = 0; i < 22; i++) begin
            run_phase(tbl[i].en, tbl[i].up_hi, tbl[i].both, tbl[i].period, tbl[i].cycles);
            check_vals($sformatf("phase%0d", i), tbl[i].x_st, tbl[i].x_pr, tbl[i].x_cp,
                       tbl[i].x_fm, tbl[i].x_lk, tbl[i].x_ft, tbl[i].x_er);
        end

        // Asynchronous reset pulse while locked.
        run_phase(1, 0, 0, 0, 33);
        run_phase(1, 1, 0, 100, 1700);
        check_vals("pre_rst_locked", 3, 1, 1, 0, 1, 0, 1);
        #2;
        resetb = 1'b0;
        #1;
        check_vals("async_rst", 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
        run_phase(1, 0, 0, 0, 5);
        check_vals("after_rst", 1, 0, 0, 0, 0, 0, 0);

        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
